julia_frame_scheduler: RTL and testbench
========================================

// Module: julia_frame_scheduler
// PURPOSE
// Walks a WIDTH x HEIGHT pixel grid, computes each pixel's initial z, and dispatches
// pixels to NUM_CORES julia iteration cores. Collects each core's iteration count
// through a round-robin arbiter and emits one tagged (px, py, iter) result per
// handshake. Sits between the frame-config registers and the pixel writer.
// PARAMETERS
// NUM_CORES        4   number of attached julia cores (1..16)
// DATA_WIDTH       32  fixed-point width, signed Q(DATA_WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS
// FRACTIONAL_BITS  24  fractional bits of all coordinates/constants
// MAX_ITER_WIDTH   16  iteration count width
// COORD_WIDTH      11  pixel coordinate width
// PORTS
// clk_i          in   1                       clock
// rst_i          in   1                       reset, asynchronous, active-high
// frame_start_i  in   1                       start frame; accepted only in IDLE
// width_i        in   COORD_WIDTH             pixels per row
// height_i       in   COORD_WIDTH             rows
// x0_i, y0_i     in   DATA_WIDTH              z of pixel (0,0)
// dx_i, dy_i     in   DATA_WIDTH              z step per column / per row
// cx_i, cy_i     in   DATA_WIDTH              julia constant c
// max_iter_i     in   MAX_ITER_WIDTH          iteration limit
// core_start_o   out  NUM_CORES               one-hot 1-cycle start pulse per core
// core_zx_o      out  DATA_WIDTH              broadcast initial zx (valid with start)
// core_zy_o      out  DATA_WIDTH              broadcast initial zy
// core_cx_o, core_cy_o  out  DATA_WIDTH       latched c, stable for whole frame
// core_max_iter_o  out  MAX_ITER_WIDTH        latched limit, stable for whole frame
// core_done_i    in   NUM_CORES               per-core done (level, cleared by core after start)
// core_iter_i    in   NUM_CORES*MAX_ITER_WIDTH  per-core iter count, core k at [k*W +: W]
// res_valid_o    out  1                       result register holds a result
// res_ready_i    in   1                       consumer accepts result
// res_px_o, res_py_o  out  COORD_WIDTH        pixel of result
// res_iter_o     out  MAX_ITER_WIDTH          iteration count of result
// busy_o         out  1                       state != IDLE
// frame_done_o   out  1                       1-cycle pulse, last result handed off
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, busy mask/counters/tags cleared. Cores share rst_i.
// - FSM: IDLE -(frame_start_i)-> RUN -(last pixel dispatched)-> DRAIN -(busy mask 0
//   and no result pending)-> IDLE with frame_done_o. Frame config latched at acceptance.
// - frame_start_i outside IDLE ignored. width_i or height_i == 0: frame_done_o
//   pulses the cycle after acceptance, no core_start_o, no results.
// - Dispatch (RUN): each cycle, if any core is idle, pulse core_start_o for the
//   lowest-index idle core, drive zx/zy, and store (px, py) in that core's tag reg.
//   First start pulse appears in the first RUN cycle. Max one dispatch per cycle.
// - Coordinates: px increments; at px == width-1, px=0, py++. zx accumulates
//   +dx per column and reloads x0 at row wrap; zy += dy per row. Adds wrap mod 2^DATA_WIDTH.
// - Collect: candidates = core_done_i & busy mask. When result reg is empty or being
//   drained (res_valid_o & res_ready_i), round-robin grant (pointer = winner+1)
//   loads (tag, iter) into result reg; res_valid_o rises next cycle. Granted core
//   cleared from busy mask; it is not redispatchable in the same cycle.
// - Throughput: 1 result/cycle with res_ready_i high. res_* stable while
//   res_valid_o & !res_ready_i. Backpressure stalls cores naturally (busy until
//   collected); dispatch continues to any remaining idle cores.
// CONFIGURATION
// - JULIA_SCHED_PERF_EN defined: adds output frame_cycles_o [31:0], counts cycles
//   from frame acceptance to frame_done_o inclusive, saturates at 2^32-1, holds
//   until next acceptance, reset 0. Undefined: port and counter absent, no other change.
// TESTING
// - 4x1 frame, x0=-2.0, dx=1.0, y0=dy=0, c=0, max_iter=10 -> results (0,0)=1,
//   (1,0)=10, (2,0)=10, (3,0)=10 (any order), then one frame_done_o pulse.
// - Same frame, res_ready_i low 50 cycles -> res_valid_o high with stable data,
//   exactly 4 start pulses total; release -> remaining results, frame_done_o.
// - width_i=0 -> frame_done_o 1 cycle after start, no core_start_o, no res_valid_o.
// - Two cores done in same cycle, repeated -> grants alternate per round-robin pointer.
// - frame_start_i in RUN ignored; rst_i mid-frame -> all outputs 0, next frame ok.
// - JULIA_SCHED_PERF_EN: width 0 frame -> frame_cycles_o == 2.

Source files
------------

// File: rtl/julia_frame_scheduler.sv
// Julia frame scheduler: walks the pixel grid, dispatches initial z to a pool of cores,
// collects iteration counts round-robin. Optional macro JULIA_SCHED_PERF_EN adds frame_cycles_o.
module julia_frame_scheduler #(
  parameter int NUM_CORES       = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int COORD_WIDTH     = 11
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                frame_start_i,
  input  logic [COORD_WIDTH-1:0]              width_i,
  input  logic [COORD_WIDTH-1:0]              height_i,
  input  logic [DATA_WIDTH-1:0]               x0_i,
  input  logic [DATA_WIDTH-1:0]               y0_i,
  input  logic [DATA_WIDTH-1:0]               dx_i,
  input  logic [DATA_WIDTH-1:0]               dy_i,
  input  logic [DATA_WIDTH-1:0]               cx_i,
  input  logic [DATA_WIDTH-1:0]               cy_i,
  input  logic [MAX_ITER_WIDTH-1:0]           max_iter_i,
  output logic [NUM_CORES-1:0]                core_start_o,
  output logic [DATA_WIDTH-1:0]               core_zx_o,
  output logic [DATA_WIDTH-1:0]               core_zy_o,
  output logic [DATA_WIDTH-1:0]               core_cx_o,
  output logic [DATA_WIDTH-1:0]               core_cy_o,
  output logic [MAX_ITER_WIDTH-1:0]           core_max_iter_o,
  input  logic [NUM_CORES-1:0]                core_done_i,
  input  logic [NUM_CORES*MAX_ITER_WIDTH-1:0] core_iter_i,
  output logic                                res_valid_o,
  input  logic                                res_ready_i,
  output logic [COORD_WIDTH-1:0]              res_px_o,
  output logic [COORD_WIDTH-1:0]              res_py_o,
  output logic [MAX_ITER_WIDTH-1:0]           res_iter_o,
  output logic                                busy_o,
  output logic                                frame_done_o
`ifdef JULIA_SCHED_PERF_EN
  ,
  output logic [31:0]                         frame_cycles_o
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  if (FRACTIONAL_BITS >= DATA_WIDTH || NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_cfg
    $error("julia_frame_scheduler: unsupported parameter set");
  end

  // Returns {found, index} of the first candidate at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CORES-1:0] cand,
                                             input logic [IDX_W-1:0]     ptr);
    logic [IDX_W:0] pick;
    int j;
    pick = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (cand[j]) pick = {1'b1, IDX_W'(j)};
    end
    return pick;
  endfunction

  logic [1:0]                    state_q;
  logic [COORD_WIDTH-1:0]        width_q, height_q;
  logic [COORD_WIDTH-1:0]        px_p0, py_p0;
  logic signed [DATA_WIDTH-1:0]  x0_q, dx_q, dy_q;
  logic signed [DATA_WIDTH-1:0]  zx_p0, zy_p0;
  logic [NUM_CORES-1:0]          busy_q;
  logic [2*COORD_WIDTH-1:0]      tag_q [NUM_CORES];
  logic [IDX_W-1:0]              rr_ptr_q;

  logic                          accept, empty_frame, dispatch, last_px, last_pixel;
  logic [NUM_CORES-1:0]          start_oh, cand, grant_oh;
  logic [IDX_W:0]                pick;
  logic [IDX_W-1:0]              grant_idx;
  logic                          load_ok, grant, drain_done;
  logic [2*COORD_WIDTH-1:0]      grant_tag;
  logic [MAX_ITER_WIDTH-1:0]     grant_iter;

  assign accept      = (state_q == S_IDLE) && frame_start_i;
  assign empty_frame = (width_i == '0) || (height_i == '0);
  assign last_px     = (px_p0 == width_q - COORD_WIDTH'(1));
  assign last_pixel  = last_px && (py_p0 == height_q - COORD_WIDTH'(1));

  // Stage p0: dispatch to the lowest-index idle core
  always_comb begin
    start_oh = '0;
    if (state_q == S_RUN) begin
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
        if (!busy_q[k]) begin
          start_oh    = '0;
          start_oh[k] = 1'b1;
        end
      end
    end
  end

  assign dispatch     = |start_oh;
  assign core_start_o = start_oh;
  assign core_zx_o    = zx_p0;
  assign core_zy_o    = zy_p0;
  assign busy_o       = (state_q != S_IDLE);

  // Stage p1: round-robin collect into the result register
  assign cand       = core_done_i & busy_q;
  assign load_ok    = !res_valid_o || res_ready_i;
  assign pick       = rr_pick(cand, rr_ptr_q);
  assign grant_idx  = pick[IDX_W-1:0];
  assign grant      = load_ok && pick[IDX_W];
  assign drain_done = (state_q == S_DRAIN) && (busy_q == '0) && load_ok;

  always_comb begin
    grant_oh   = '0;
    grant_tag  = '0;
    grant_iter = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (k == int'(grant_idx)) begin
        grant_oh[k] = grant;
        grant_tag   = tag_q[k];
        grant_iter  = core_iter_i[k*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      frame_done_o <= 1'b0;
      busy_q       <= '0;
      rr_ptr_q     <= '0;
      res_valid_o  <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start_i) begin
            if (empty_frame) frame_done_o <= 1'b1;
            else             state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          if (dispatch && last_pixel) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            state_q      <= S_IDLE;
            frame_done_o <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A core granted this cycle stays masked until the next cycle.
      busy_q <= (busy_q & ~grant_oh) | start_oh;
      if (grant) begin
        res_valid_o <= 1'b1;
        rr_ptr_q    <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
      end else if (res_ready_i) begin
        res_valid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      width_q         <= '0;
      height_q        <= '0;
      px_p0           <= '0;
      py_p0           <= '0;
      x0_q            <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      zx_p0           <= '0;
      zy_p0           <= '0;
      core_cx_o       <= '0;
      core_cy_o       <= '0;
      core_max_iter_o <= '0;
      res_px_o        <= '0;
      res_py_o        <= '0;
      res_iter_o      <= '0;
      for (int k = 0; k < NUM_CORES; k++) tag_q[k] <= '0;
    end else begin
      if (accept) begin
        width_q         <= width_i;
        height_q        <= height_i;
        x0_q            <= $signed(x0_i);
        dx_q            <= $signed(dx_i);
        dy_q            <= $signed(dy_i);
        core_cx_o       <= cx_i;
        core_cy_o       <= cy_i;
        core_max_iter_o <= max_iter_i;
        px_p0           <= '0;
        py_p0           <= '0;
        zx_p0           <= $signed(x0_i);
        zy_p0           <= $signed(y0_i);
      end else if (dispatch) begin
        if (last_px) begin
          px_p0 <= '0;
          py_p0 <= py_p0 + COORD_WIDTH'(1);
          zx_p0 <= x0_q;
          zy_p0 <= zy_p0 + dy_q;
        end else begin
          px_p0 <= px_p0 + COORD_WIDTH'(1);
          zx_p0 <= zx_p0 + dx_q;
        end
      end
      for (int k = 0; k < NUM_CORES; k++) begin
        if (start_oh[k]) tag_q[k] <= {py_p0, px_p0};
      end
      if (grant) begin
        res_px_o   <= grant_tag[COORD_WIDTH-1:0];
        res_py_o   <= grant_tag[2*COORD_WIDTH-1:COORD_WIDTH];
        res_iter_o <= grant_iter;
      end
    end
  end

`ifdef JULIA_SCHED_PERF_EN
  logic perf_run_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counts from the acceptance cycle through the frame_done_o cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cycles_o <= '0;
      perf_run_q     <= 1'b0;
    end else if (accept) begin
      frame_cycles_o <= 32'd1;
      perf_run_q     <= 1'b1;
    end else if (perf_run_q) begin
      frame_cycles_o <= sat_inc32(frame_cycles_o);
      if (frame_done_o) perf_run_q <= 1'b0;
    end
  end
`else
  // Frame timer not built in this configuration.
`endif

endmodule

// File: tb/tb_julia_frame_scheduler.sv
// Self-checking bench for julia_frame_scheduler with behavioural julia cores and a
// pixel-level reference model of the expected frame results.
module tb_julia_frame_scheduler;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int CW = 11;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              frame_start_i = 1'b0;
  logic [CW-1:0]     width_i = '0, height_i = '0;
  logic [DW-1:0]     x0_i = '0, y0_i = '0, dx_i = '0, dy_i = '0, cx_i = '0, cy_i = '0;
  logic [IW-1:0]     max_iter_i = '0;
  logic [NC-1:0]     core_start_o;
  logic [DW-1:0]     core_zx_o, core_zy_o, core_cx_o, core_cy_o;
  logic [IW-1:0]     core_max_iter_o;
  logic [NC-1:0]     core_done_i;
  logic [NC*IW-1:0]  core_iter_i;
  logic              res_valid_o;
  logic              res_ready_i = 1'b1;
  logic [CW-1:0]     res_px_o, res_py_o;
  logic [IW-1:0]     res_iter_o;
  logic              busy_o, frame_done_o;

  always #5 clk_i = ~clk_i;

  julia_frame_scheduler #(.NUM_CORES(NC), .DATA_WIDTH(DW), .FRACTIONAL_BITS(24),
                          .MAX_ITER_WIDTH(IW), .COORD_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start_i),
    .width_i(width_i), .height_i(height_i),
    .x0_i(x0_i), .y0_i(y0_i), .dx_i(dx_i), .dy_i(dy_i), .cx_i(cx_i), .cy_i(cy_i),
    .max_iter_i(max_iter_i),
    .core_start_o(core_start_o), .core_zx_o(core_zx_o), .core_zy_o(core_zy_o),
    .core_cx_o(core_cx_o), .core_cy_o(core_cy_o), .core_max_iter_o(core_max_iter_o),
    .core_done_i(core_done_i), .core_iter_i(core_iter_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_px_o(res_px_o), .res_py_o(res_py_o), .res_iter_o(res_iter_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  // Escape-time count in Q8.24: iterate while |z|^2 <= 4 and below the limit.
  function automatic int julia_ref(input logic signed [31:0] zx0, input logic signed [31:0] zy0,
                                   input logic signed [31:0] cx, input logic signed [31:0] cy,
                                   input int maxit);
    longint zx, zy, x2, y2, nzx;
    int n;
    zx = zx0; zy = zy0; n = 0;
    while (n < maxit) begin
      x2 = (zx * zx) >>> 24;
      y2 = (zy * zy) >>> 24;
      if (x2 + y2 > 64'sd67108864) break;
      nzx = x2 - y2 + longint'(cx);
      zy  = ((2 * zx * zy) >>> 24) + longint'(cy);
      zx  = nzx;
      n++;
    end
    return n;
  endfunction

  // Behavioural cores: done drops on start, rises after a latency with the count.
  int            fixed_lat = 0;
  logic [NC-1:0] done_r;
  logic [IW-1:0] iter_r [NC];
  int            rem [NC];
  int            pend [NC];

  assign core_done_i = done_r;
  for (genvar g = 0; g < NC; g++) begin : g_pack
    assign core_iter_i[g*IW +: IW] = iter_r[g];
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NC; k++) begin
        done_r[k] <= 1'b0; iter_r[k] <= '0; rem[k] <= 0; pend[k] <= 0;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (core_start_o[k]) begin
          done_r[k] <= 1'b0;
          rem[k]    <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
          pend[k]   <= julia_ref(core_zx_o, core_zy_o, core_cx_o, core_cy_o, int'(core_max_iter_o));
        end else if (rem[k] > 0) begin
          rem[k] <= rem[k] - 1;
          if (rem[k] == 1) begin
            done_r[k] <= 1'b1;
            iter_r[k] <= IW'(pend[k]);
          end
        end
      end
    end
  end

  typedef struct { int px; int py; int iter; } res_t;
  res_t res_q[$];
  int start_cnt = 0, done_cnt = 0, valid_cnt = 0, multi_start = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (res_valid_o && res_ready_i)
        res_q.push_back('{int'(res_px_o), int'(res_py_o), int'(res_iter_o)});
      if (res_valid_o) valid_cnt++;
      start_cnt += $countones(core_start_o);
      if ($countones(core_start_o) > 1) multi_start++;
      if (frame_done_o) done_cnt++;
    end
  end

  int checks = 0, errors = 0;
  int f_w, f_h, f_x0, f_dx, f_y0, f_dy, f_cx, f_cy, f_mi;
  int res_base, start_base, done_base, valid_base;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  function automatic int exp_iter(input int px, input int py);
    return julia_ref(f_x0 + px * f_dx, f_y0 + py * f_dy, f_cx, f_cy, f_mi);
  endfunction

  task automatic start_frame(input int w, input int h, input int x0, input int dx, input int y0,
                             input int dy, input int cx, input int cy, input int mi);
    f_w = w; f_h = h; f_x0 = x0; f_dx = dx; f_y0 = y0; f_dy = dy; f_cx = cx; f_cy = cy; f_mi = mi;
    res_base = res_q.size(); start_base = start_cnt; done_base = done_cnt; valid_base = valid_cnt;
    width_i = CW'(w); height_i = CW'(h);
    x0_i = x0; dx_i = dx; y0_i = y0; dy_i = dy; cx_i = cx; cy_i = cy; max_iter_i = IW'(mi);
    frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int mode, input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) begin
      res_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1);
    end
    res_ready_i = 1'b1;
    check({tag, " frame_done"}, done_cnt - done_base, 1);
    step(4);
    check({tag, " single done pulse"}, done_cnt - done_base, 1);
    check({tag, " idle after"}, {res_valid_o, busy_o}, 0);
  endtask

  task automatic check_frame(input string tag);
    bit seen [int];
    int n, uniq;
    res_t r;
    n = res_q.size() - res_base;
    uniq = 0;
    check({tag, " result count"}, n, f_w * f_h);
    check({tag, " start pulses"}, start_cnt - start_base, f_w * f_h);
    check({tag, " one-hot starts"}, multi_start, 0);
    for (int i = 0; i < n; i++) begin
      r = res_q[res_base + i];
      if (r.px < f_w && r.py < f_h && !seen.exists(r.py * 4096 + r.px)) begin
        seen[r.py * 4096 + r.px] = 1'b1;
        uniq++;
        check({tag, " iter"}, r.iter, exp_iter(r.px, r.py));
      end
    end
    check({tag, " unique pixels"}, uniq, f_w * f_h);
  endtask

  localparam int ONE = 32'h0100_0000;

  initial begin
    logic [CW-1:0] cap_px, cap_py;
    logic [IW-1:0] cap_it;
    int n;

    // Reset state
    step(3);
    check("reset core_start", core_start_o, 0);
    check("reset res_valid", res_valid_o, 0);
    check("reset busy", busy_o, 0);
    check("reset frame_done", frame_done_o, 0);
    check("reset core_zx", core_zx_o, 0);
    check("reset core_cx", core_cx_o, 0);
    check("reset max_iter", core_max_iter_o, 0);
    check("reset res_iter", res_iter_o, 0);
    rst_i = 1'b0;
    step(2);

    // 4x1 reference frame
    start_frame(4, 1, -2 * ONE, ONE, 0, 0, 0, 0, 10);
    check("t1 first start pulse", core_start_o, 4'b0001);
    check("t1 busy", busy_o, 1);
    check("t1 zx of pixel 0", $signed(core_zx_o), -2 * ONE);
    run_to_done("t1", 0, 200);
    check_frame("t1");
    n = res_q.size() - res_base;
    for (int i = 0; i < n; i++)
      check("t1 spec iter", res_q[res_base + i].iter, (res_q[res_base + i].px == 0) ? 1 : 10);

    // Same frame with 50 cycles of backpressure
    res_ready_i = 1'b0;
    start_frame(4, 1, -2 * ONE, ONE, 0, 0, 0, 0, 10);
    step(20);
    check("t2 valid under stall", res_valid_o, 1);
    cap_px = res_px_o; cap_py = res_py_o; cap_it = res_iter_o;
    check("t2 held iter", cap_it, (cap_px == 0) ? 1 : 10);
    step(30);
    check("t2 still valid", res_valid_o, 1);
    check("t2 px stable", res_px_o, cap_px);
    check("t2 py stable", res_py_o, cap_py);
    check("t2 iter stable", res_iter_o, cap_it);
    check("t2 starts during stall", start_cnt - start_base, 4);
    run_to_done("t2", 0, 200);
    check_frame("t2");

    // Empty frames
    start_frame(0, 3, ONE, ONE, 0, 0, 0, 0, 5);
    check("t3 w0 done next cycle", frame_done_o, 1);
    check("t3 w0 no start", core_start_o, 0);
    step(1);
    check("t3 w0 done is a pulse", frame_done_o, 0);
    step(4);
    check("t3 w0 start count", start_cnt - start_base, 0);
    check("t3 w0 no results", valid_cnt - valid_base, 0);
    check("t3 w0 done count", done_cnt - done_base, 1);
    start_frame(3, 0, ONE, ONE, 0, 0, 0, 0, 5);
    check("t3 h0 done next cycle", frame_done_o, 1);
    step(4);
    check("t3 h0 start count", start_cnt - start_base, 0);
    check("t3 h0 no results", valid_cnt - valid_base, 0);

    // Simultaneous done cores: grant order must follow the rotating pointer
    fixed_lat = 5;
    res_ready_i = 1'b0;
    start_frame(8, 1, -2 * ONE, ONE / 2, 0, 0, ONE / 4, 0, 12);
    step(40);
    run_to_done("t4", 0, 300);
    check_frame("t4");
    n = res_q.size() - res_base;
    for (int i = 0; i < n && i < 8; i++)
      check("t4 rr order px", res_q[res_base + i].px, i);
    fixed_lat = 0;

    // frame_start while running is ignored
    start_frame(4, 2, -ONE, ONE / 4, -ONE / 2, ONE / 4, -ONE / 2, ONE / 3, 15);
    step(2);
    width_i = CW'(1); height_i = CW'(1); x0_i = 32'h0300_0000; max_iter_i = IW'(3);
    frame_start_i = 1'b1;
    step(1);
    frame_start_i = 1'b0;
    check("t5 latched max_iter", core_max_iter_o, 15);
    run_to_done("t5", 1, 500);
    check_frame("t5");

    // Reset mid-frame, then a fresh frame
    start_frame(5, 3, -ONE, ONE / 3, -ONE, ONE / 2, 0, ONE / 2, 20);
    step(6);
    rst_i = 1'b1;
    #1;
    check("t6 reset busy", busy_o, 0);
    check("t6 reset starts", core_start_o, 0);
    check("t6 reset res_valid", res_valid_o, 0);
    check("t6 reset res_px", res_px_o, 0);
    check("t6 reset res_iter", res_iter_o, 0);
    check("t6 reset core_cx", core_cx_o, 0);
    check("t6 reset core_zy", core_zy_o, 0);
    step(2);
    rst_i = 1'b0;
    step(1);
    start_frame(3, 2, -ONE, ONE / 2, 0, ONE / 2, -ONE / 4, 0, 9);
    run_to_done("t6", 0, 300);
    check_frame("t6");

    // Randomised frames with random core latency and random backpressure
    for (int t = 0; t < 6; t++) begin
      start_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)),
                  int'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000,
                  int'($urandom_range(0, 32'h0040_0000)) - 32'h0020_0000,
                  int'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000,
                  int'($urandom_range(0, 32'h0040_0000)) - 32'h0020_0000,
                  int'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000,
                  int'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000,
                  int'($urandom_range(1, 20)));
      run_to_done("rnd", 1, 600);
      check_frame("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
